// File: rtl/tetris_pkg.sv
// Shared board-size defaults, scheduler FSM encoding and score table for the
// line-clear scheduler.
package tetris_pkg;

  localparam int ROWS_DEF = 20;
  localparam int COLS_DEF = 10;

  localparam logic [9:0]  TOTAL_MAX = 10'd1023;

  localparam logic [15:0] SCORE_0 = 16'd0;
  localparam logic [15:0] SCORE_1 = 16'd40;
  localparam logic [15:0] SCORE_2 = 16'd100;
  localparam logic [15:0] SCORE_3 = 16'd300;
  localparam logic [15:0] SCORE_4 = 16'd1200;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    DRAIN = 3'd2,
    EVAL  = 3'd3,
    CLEAR = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Four or more simultaneous lines all earn the top award.
  function automatic logic [15:0] score_lookup(input logic [4:0] lines);
    case (lines)
      5'd0:    score_lookup = SCORE_0;
      5'd1:    score_lookup = SCORE_1;
      5'd2:    score_lookup = SCORE_2;
      5'd3:    score_lookup = SCORE_3;
      default: score_lookup = SCORE_4;
    endcase
  endfunction

endpackage

// File: rtl/clear_line_sched_if.sv
// Board-read and clear-engine signal bundle between the scheduler (master)
// and the board/clear logic (slave).
interface clear_line_sched_if #(
  parameter int COLS = 10
);
  // row_rd_en/row_rd_addr issue one read per cycle with no backpressure;
  // row_rd_data is valid exactly one cycle after the strobe. clr_enable is a
  // level held until clr_done is sampled high; clr_done is ignored otherwise.
  logic            row_rd_en;
  logic [4:0]      row_rd_addr;
  logic [COLS-1:0] row_rd_data;
  logic            clr_enable;
  logic            clr_done;

  modport master (
    output row_rd_en, row_rd_addr, clr_enable,
    input  row_rd_data, clr_done
  );

  modport slave (
    input  row_rd_en, row_rd_addr, clr_enable,
    output row_rd_data, clr_done
  );
endinterface

// File: rtl/line_popcount.sv
// Combinational count of the set bits in the full-row vector.
module line_popcount #(
  parameter int ROWS = 20
) (
  input  logic [0:ROWS-1] bits,
  output logic [4:0]      count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < ROWS; i++) begin
      count = count + 5'(bits[i]);
    end
  end

endmodule

// File: rtl/clear_line_sched.sv
// Scans the board after a piece lock, flags full rows, runs the clear engine
// and keeps line/score totals. Score accumulation is built only with CLEAR_SCORE_EN.
module clear_line_sched
  import tetris_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                lock_req,
  output logic                lock_ack,
  output logic                busy,
  clear_line_sched_if.master  bus,
  output logic [0:ROWS-1]     line_full,
  output logic [4:0]          lines_cleared,
  output logic [9:0]          total_lines,
  output logic [15:0]         score,
  output state_t              fsm_state
);

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  state_t          state, state_nxt;
  logic [4:0]      addr;
  logic            rd_vld;
  logic [4:0]      rd_addr_q;
  logic [4:0]      pop;
  logic [10:0]     total_sum;
  logic [COLS-1:0] row_q;
  logic            rd_en;
  logic            clr_en;

  assign row_q     = bus.row_rd_data;
  assign total_sum = {1'b0, total_lines} + {6'd0, lines_cleared};
  assign fsm_state = state;

  line_popcount #(.ROWS(ROWS)) u_popcount (
    .bits  (line_full),
    .count (pop)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      addr          <= '0;
      rd_vld        <= 1'b0;
      rd_addr_q     <= '0;
      line_full     <= '0;
      lines_cleared <= '0;
      total_lines   <= '0;
    end else begin
      state     <= state_nxt;
      rd_vld    <= (state == SCAN);
      rd_addr_q <= addr;
      if (state == IDLE && lock_req) begin
        line_full <= '0;
        addr      <= '0;
      end else if (state == SCAN) begin
        addr <= addr + 5'd1;
      end
      // Read data trails the strobe by one cycle, so index with the delayed address.
      if (rd_vld) line_full[rd_addr_q] <= &row_q;
      if (state == EVAL) lines_cleared <= pop;
      if (state == DONE) total_lines <= total_sum[10] ? TOTAL_MAX : total_sum[9:0];
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    lock_ack  = 1'b0;
    rd_en     = 1'b0;
    clr_en    = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (lock_req) state_nxt = SCAN;
      end
      SCAN: begin
        rd_en = 1'b1;
        if (addr == LAST_ROW) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = EVAL;
      EVAL:  state_nxt = (pop == 5'd0) ? DONE : CLEAR;
      CLEAR: begin
        clr_en = 1'b1;
        if (bus.clr_done) state_nxt = DONE;
      end
      DONE: begin
        lock_ack  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.row_rd_en   = rd_en;
  assign bus.row_rd_addr = rd_en ? addr : 5'd0;
  assign bus.clr_enable  = clr_en;

`ifdef CLEAR_SCORE_EN
  logic [15:0] score_r;
  logic [16:0] score_sum;

  assign score_sum = {1'b0, score_r} + {1'b0, score_lookup(lines_cleared)};

  always_ff @(posedge clk) begin
    if (!reset) begin
      score_r <= '0;
    end else if (state == DONE) begin
      score_r <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
  end

  assign score = score_r;
`else
  assign score = '0;
`endif

endmodule

// File: tb/tb_clear_line_sched.sv
// Randomized bench for clear_line_sched: board memory model, behavioural
// reference for full rows, timing, totals and score.
`timescale 1ns/1ps
module tb_clear_line_sched;
  import tetris_pkg::*;

  localparam int ROWS   = ROWS_DEF;
  localparam int COLS   = COLS_DEF;
  localparam int BUDGET = 200;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              lock_req = 1'b0;
  logic              lock_ack;
  logic              busy;
  logic [0:ROWS-1]   line_full;
  logic [4:0]        lines_cleared;
  logic [9:0]        total_lines;
  logic [15:0]       score;
  state_t            fsm_state;

  clear_line_sched_if #(.COLS(COLS)) bus ();

  clear_line_sched #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk           (clk),
    .reset         (reset),
    .lock_req      (lock_req),
    .lock_ack      (lock_ack),
    .busy          (busy),
    .bus           (bus),
    .line_full     (line_full),
    .lines_cleared (lines_cleared),
    .total_lines   (total_lines),
    .score         (score),
    .fsm_state     (fsm_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Board memory model: one-cycle read latency, junk when not reading.
  logic [COLS-1:0] board [ROWS];
  logic [4:0]      rd_q [$];
  logic [4:0]      exp_q [$];
  logic            rsp_en;
  logic [4:0]      rsp_addr;

  always @(posedge clk) begin
    rsp_en   = bus.row_rd_en;
    rsp_addr = bus.row_rd_addr;
    if (rsp_en) rd_q.push_back(rsp_addr);
    #1;
    bus.row_rd_data = (rsp_en && rsp_addr < ROWS) ? board[rsp_addr] : COLS'($urandom);
  end

  // Scoreboard state
  int n_vec = 0;
  int n_err = 0;
  int exp_total = 0;
  int exp_score = 0;

  function automatic int model_lines();
    int n = 0;
    for (int r = 0; r < ROWS; r++) if (board[r] == {COLS{1'b1}}) n++;
    return n;
  endfunction

  function automatic logic [0:ROWS-1] model_full();
    logic [0:ROWS-1] f;
    for (int r = 0; r < ROWS; r++) f[r] = (board[r] == {COLS{1'b1}});
    return f;
  endfunction

  function automatic int score_of(input int n);
    if (n == 0) return 0;
    if (n == 1) return 40;
    if (n == 2) return 100;
    if (n == 3) return 300;
    return 1200;
  endfunction

  function automatic void board_rows(input int lo, input int hi);
    for (int r = 0; r < ROWS; r++)
      board[r] = (r >= lo && r <= hi) ? {COLS{1'b1}} : (COLS'($urandom) & ~COLS'(1));
  endfunction

  // Driver: one full lock sequence. d = CLEAR cycles before clr_done is given.
  // spurious: hold clr_done high through SCAN/DRAIN. poke: lock_req while busy.
  // chain: raise lock_req in the first IDLE cycle after the sequence.
  task automatic run_seq(input int d, input bit spurious, input bit poke, input bit chain);
    int n, ack_at, en_cnt, exp_ack;
    bit busy_bad, rd_bad;
    logic [0:ROWS-1] exp_full;
    n        = model_lines();
    exp_full = model_full();
    exp_ack  = (n == 0) ? ROWS + 3 : ROWS + 3 + d;
    rd_q.delete();
    exp_q.delete();
    for (int r = 0; r < ROWS; r++) exp_q.push_back(5'(r));
    if (!lock_req) begin
      @(negedge clk);
      lock_req = 1'b1;
    end
    @(negedge clk);
    lock_req = 1'b0;
    ack_at = -1; en_cnt = 0; busy_bad = 1'b0;
    for (int k = 1; k <= BUDGET && ack_at < 0; k++) begin
      if (k > 1) @(negedge clk);
      lock_req = poke && (k == 5 || k == exp_ack);
      if (lock_ack === 1'b1) ack_at = k;
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (bus.clr_enable === 1'b1) en_cnt++;
      bus.clr_done = (spurious && k <= ROWS + 1) || (bus.clr_enable === 1'b1 && en_cnt == d);
    end
    lock_req = 1'b0;
    bus.clr_done = 1'b0;

    n_vec++;
    if (ack_at !== exp_ack) begin
      n_err++; $display("FAIL ack_cycle: got %0d expected %0d", ack_at, exp_ack);
    end
    n_vec++;
    if (en_cnt !== ((n == 0) ? 0 : d)) begin
      n_err++; $display("FAIL clr_enable_cycles: got %0d expected %0d", en_cnt, (n == 0) ? 0 : d);
    end
    n_vec++;
    if (busy_bad) begin
      n_err++; $display("FAIL busy_during_seq: got low expected high");
    end
    rd_bad = (rd_q.size() != exp_q.size());
    for (int i = 0; i < rd_q.size() && !rd_bad; i++) if (rd_q[i] !== exp_q[i]) rd_bad = 1'b1;
    n_vec++;
    if (rd_bad) begin
      n_err++; $display("FAIL read_seq: got %0d reads expected %0d ascending from 0", rd_q.size(), exp_q.size());
    end

    exp_total = (exp_total + n > 1023) ? 1023 : exp_total + n;
`ifdef CLEAR_SCORE_EN
    exp_score = (exp_score + score_of(n) > 65535) ? 65535 : exp_score + score_of(n);
`endif

    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || lock_ack !== 1'b0) begin
      n_err++; $display("FAIL idle_after: got busy=%0b ack=%0b expected 0 0", busy, lock_ack);
    end
    n_vec++;
    if (line_full !== exp_full) begin
      n_err++; $display("FAIL line_full: got %h expected %h", line_full, exp_full);
    end
    n_vec++;
    if (lines_cleared !== 5'(n)) begin
      n_err++; $display("FAIL lines_cleared: got %0d expected %0d", lines_cleared, n);
    end
    n_vec++;
    if (total_lines !== 10'(exp_total)) begin
      n_err++; $display("FAIL total_lines: got %0d expected %0d", total_lines, exp_total);
    end
    n_vec++;
    if (score !== 16'(exp_score)) begin
      n_err++; $display("FAIL score: got %0d expected %0d", score, exp_score);
    end
    lock_req = chain;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.clr_done = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (fsm_state !== IDLE || busy !== 1'b0 || lock_ack !== 1'b0) begin
      n_err++; $display("FAIL reset_ctrl: got state=%0d busy=%0b ack=%0b expected 0 0 0", fsm_state, busy, lock_ack);
    end
    n_vec++;
    if (bus.row_rd_en !== 1'b0 || bus.row_rd_addr !== 5'd0 || bus.clr_enable !== 1'b0) begin
      n_err++; $display("FAIL reset_bus: got en=%0b addr=%0d clr=%0b expected 0 0 0",
                        bus.row_rd_en, bus.row_rd_addr, bus.clr_enable);
    end
    n_vec++;
    if (line_full !== '0 || lines_cleared !== '0 || total_lines !== '0 || score !== '0) begin
      n_err++; $display("FAIL reset_data: got full=%h lc=%0d tot=%0d score=%0d expected all 0",
                        line_full, lines_cleared, total_lines, score);
    end
    reset = 1'b1;
    exp_total = 0;
    exp_score = 0;
  endtask

  task automatic test_empty();
    for (int r = 0; r < ROWS; r++) board[r] = COLS'($urandom) & ~COLS'(2);
    run_seq(1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_single_row();
    board_rows(ROWS - 1, ROWS - 1);
    run_seq(5, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_four_rows_poke();
    bit extra;
    board_rows(16, 19);
    run_seq(3, 1'b0, 1'b1, 1'b0);
    extra = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (lock_ack !== 1'b0 || busy !== 1'b0) extra = 1'b1;
    end
    n_vec++;
    if (extra) begin
      n_err++; $display("FAIL no_queued_seq: got activity expected idle");
    end
  endtask

  task automatic test_back_to_back();
    board_rows(3, 4);
    run_seq(2, 1'b0, 1'b0, 1'b1);
    board_rows(10, 10);
    run_seq(1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_spurious_done();
    bit moved;
    moved = 1'b0;
    bus.clr_done = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b0 || fsm_state !== IDLE) moved = 1'b1;
    end
    bus.clr_done = 1'b0;
    n_vec++;
    if (moved) begin
      n_err++; $display("FAIL idle_clr_done: got state=%0d expected IDLE", fsm_state);
    end
    board_rows(ROWS - 1, ROWS - 1);
    run_seq(1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_abort_reset();
    bit seen, ack;
    board_rows(16, 19);
    @(negedge clk); lock_req = 1'b1;
    @(negedge clk); lock_req = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < BUDGET && !seen; k++) begin
      @(negedge clk);
      seen = (bus.clr_enable === 1'b1);
    end
    n_vec++;
    if (!seen) begin
      n_err++; $display("FAIL reach_clear: got no clr_enable expected high");
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || lock_ack !== 1'b0 || bus.clr_enable !== 1'b0 || bus.row_rd_en !== 1'b0 ||
        line_full !== '0 || lines_cleared !== '0 || total_lines !== '0 || score !== '0) begin
      n_err++; $display("FAIL abort_reset: got busy=%0b clr=%0b full=%h lc=%0d tot=%0d expected all 0",
                        busy, bus.clr_enable, line_full, lines_cleared, total_lines);
    end
    reset = 1'b1;
    exp_total = 0;
    exp_score = 0;
    ack = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (lock_ack !== 1'b0) ack = 1'b1;
    end
    n_vec++;
    if (ack) begin
      n_err++; $display("FAIL aborted_ack: got lock_ack expected none");
    end
    board_rows(0, 0);
    run_seq(3, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    board_rows(16, 19);
    for (int i = 0; i < 257; i++) run_seq(1, 1'b0, 1'b0, (i % 2) == 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      for (int r = 0; r < ROWS; r++)
        board[r] = ($urandom_range(0, 2) == 0) ? {COLS{1'b1}} : COLS'($urandom);
      run_seq($urandom_range(1, 8), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    bus.clr_done = 1'b0;
    for (int r = 0; r < ROWS; r++) board[r] = '0;
    test_reset();
    test_empty();
    test_single_row();
    test_four_rows_poke();
    test_back_to_back();
    test_spurious_done();
    test_abort_reset();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
